mem_responder: RTL and testbench
================================

# mem_responder

Word-organised memory responder that serves the multicycle core's instruction and data accesses over a valid/ready request channel with a fixed, parameterised response latency. It sits on the far side of the core's memory port. It accepts one request at a time, holds it for a programmable number of wait states, then commits the write or returns the read word with an error flag. It gives the core a realistic slow memory and lets the control FSM be exercised against stall conditions.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024 — number of 32-bit words in the backing array; power of two, ≥ 4.
- `BASE_ADDR`, 32'h0000_0000 — byte address of word 0; must be a multiple of 4.
- `WAIT_CYCLES`, 2 — wait states inserted between acceptance and response; range 0–15.

Ports:
- `clk` in 1 — single clock; all state changes on its rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — responder can accept a request this cycle.
- `req_addr` in 32 — byte address.
- `req_we` in 1 — 1 = write, 0 = read.
- `req_wstrb` in 4 — byte enables; bit i enables `req_wdata[8i+7:8i]`. Ignored on reads.
- `req_wdata` in 32 — write data.
- `rsp_valid` out 1 — one-cycle pulse marking the response.
- `rsp_rdata` out 32 — read data; meaningful only while `rsp_valid`=1.
- `rsp_err` out 1 — the request was rejected; meaningful only while `rsp_valid`=1.

## Operation
- States: IDLE, WAIT, RESP.
- **Reset.** While `reset`=0:
  - state is IDLE and the wait counter is 0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - The array contents are not reset.
- **IDLE.**
  - `req_ready`=1.
  - A request is accepted at a rising edge when `req_valid`=1 and `req_ready`=1.
  - On acceptance the block captures addr, we, wstrb and wdata, and loads the counter with `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES`>0, otherwise RESP.
- **WAIT.**
  - `req_ready`=0.
  - The counter decrements each edge. When the counter reads 1 at an edge, next state is RESP.
  - Input changes are ignored because all request fields are latched.
- **Transition into RESP.** Validity is checked on the captured address. The request is invalid if any of the following holds:
  - `addr[1:0]`≠0;
  - `addr` < `BASE_ADDR`;
  - `(addr−BASE_ADDR)>>2` ≥ `DEPTH_WORDS`. The subtraction is done in 32 bits, and the below-base case is detected explicitly, never through wrap-around.
- **Results, registered on the edge entering RESP.**
  - Valid read: `rsp_rdata`=word, `rsp_err`=0.
  - Valid write: array bytes with strobe=1 are updated, `rsp_rdata`=0, `rsp_err`=0. `wstrb`=0 is a legal no-op write.
  - Invalid request: no array update, `rsp_rdata`=0, `rsp_err`=1.
- **RESP.**
  - `rsp_valid`=1 and `req_ready`=0.
  - Next state is always IDLE. There is no backpressure: the core must take the response.
  - On leaving RESP, `rsp_valid` returns to 0. `rsp_rdata` and `rsp_err` hold until the next response.
- At most one request is outstanding. A request presented while `req_ready`=0 is not accepted and must be held by the initiator.

## Timing
- Acceptance cycle is cycle 0. `rsp_valid` is high in cycle 1+`WAIT_CYCLES` only.
- Throughput is one request per `WAIT_CYCLES`+2 cycles. The earliest next acceptance is in cycle 2+`WAIT_CYCLES`.
- A write is visible to a read accepted in any later cycle.
- Read-after-write to the same word with no idle gap returns the new data.
- Reset asserted mid-transaction:
  - any transaction not yet in RESP is aborted with no array write and no response;
  - outputs go to reset values immediately (asynchronously).
- Deassertion of `reset` is assumed synchronised externally. `req_ready` rises at the first edge after deassertion.

## Test plan
- **Write then read, default parameters.** Write 0xDEADBEEF to 0x10 with strobe 0xF, then read 0x10.
  - `rsp_valid` pulses in cycle 3 for each request.
  - The read returns 0xDEADBEEF with `rsp_err`=0.
  - `req_ready`=0 in cycles 1–3.
- **Byte strobes.** Write 0x11223344 (strobe 0xF) to 0x20, then write 0xAABBCCDD (strobe 0x5), then read 0x20.
  - The read returns 0x11BB33DD.
- **Error cases.** Read 0x22 (misaligned), read `4*DEPTH_WORDS` (out of range), and, with `BASE_ADDR`=0x1000, read 0x0FFC.
  - Each returns `rsp_err`=1 and `rsp_rdata`=0.
  - A misaligned write to 0x22 leaves word 0x20 unchanged.
- **`WAIT_CYCLES`=0.**
  - Back-to-back reads are accepted every 2 cycles.
  - `rsp_valid` occurs in cycle 1.
  - `req_valid` held high during RESP causes no acceptance until IDLE.
- **Reset mid-transaction.** Accept a write of 0x12345678 to 0x40, then pull `reset` low in cycle 1 (WAIT) and release it.
  - Outputs are immediately 0.
  - No `rsp_valid` is produced.
  - A later read of 0x40 returns the prior contents.
- **Input hold-off.** Change `req_addr`/`req_wdata` during WAIT.
  - The response reflects the values captured at acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-organised slow memory on the far side of the core's
// memory port. It accepts one request at a time over a valid/ready channel,
// inserts WAIT_CYCLES wait states, then commits the write or returns the
// read word together with an error flag as a one-cycle response pulse.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request this cycle
//   req_addr   in   byte address [31:0]
//   req_we     in   1 = write, 0 = read
//   req_wstrb  in   byte enables [3:0] (ignored on reads)
//   req_wdata  in   write data [31:0]
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  read data [31:0], meaningful while rsp_valid
//   rsp_err    out  request rejected, meaningful while rsp_valid
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request latched, counting down wait states
// RESP  | response presented for exactly one cycle
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
    localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        ready_en;
    logic        accept;
    logic        enter_resp;

    logic [31:0] cap_addr;
    logic        cap_we;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_wdata;

    logic [31:0] cur_addr;
    logic        cur_we;
    logic [3:0]  cur_wstrb;
    logic [31:0] cur_wdata;
    logic [29:0] word_off;
    logic        addr_ok;
    logic [IDX_W-1:0] idx;
    logic [31:0] rd_word;

    logic [31:0] mem [DEPTH_WORDS];

    // Held low through reset and for the first edge after it, so req_ready
    // only rises once the block has seen a clock out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign req_ready = ready_en && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_ready && req_valid;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RESP always exits to IDLE, so any RESP next-state is an entry.
    assign enter_resp = (state_d == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_addr  <= 32'd0;
            cap_we    <= 1'b0;
            cap_wstrb <= 4'd0;
            cap_wdata <= 32'd0;
        end else if (accept) begin
            cap_addr  <= req_addr;
            cap_we    <= req_we;
            cap_wstrb <= req_wstrb;
            cap_wdata <= req_wdata;
        end
    end

    // With no wait states RESP is entered on the acceptance edge itself, so
    // the request fields come straight from the port while in IDLE.
    assign cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign cur_we    = (state == IDLE) ? req_we    : cap_we;
    assign cur_wstrb = (state == IDLE) ? req_wstrb : cap_wstrb;
    assign cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;

    // Below-base is rejected explicitly; the word offset is only trusted
    // once that and the alignment test have passed.
    assign word_off = cur_addr[31:2] - BASE_WORD;
    assign addr_ok  = (cur_addr[1:0] == 2'b00) &&
                      (cur_addr >= BASE_ADDR) &&
                      (word_off < DEPTH_W30);
    assign idx      = word_off[IDX_W-1:0];
    assign rd_word  = mem[idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata <= (addr_ok && !cur_we) ? rd_word : 32'd0;
            rsp_err   <= !addr_ok;
        end
    end

    // Array contents survive reset; an aborted transaction never reaches
    // enter_resp because reset forces the state back to IDLE.
    always_ff @(posedge clk) begin
        if (enter_resp && addr_ok && cur_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_wstrb[b]) mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic        req_we = 1'b0;
    logic [3:0]  req_wstrb = 4'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        rdy_a, rv_a, err_a;
    logic [31:0] rd_a;
    logic        rdy_b, rv_b, err_b;
    logic [31:0] rd_b;
    logic        valid_a, valid_b;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_accept = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign valid_a = req_valid && !sel;
    assign valid_b = req_valid && sel;

    // A: default parameters. B: small array above a non-zero base, no wait states.
    mem_responder dut_a (
        .clk(clk), .reset(reset),
        .req_valid(valid_a), .req_ready(rdy_a),
        .req_addr(req_addr), .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a)
    );

    mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(valid_b), .req_ready(rdy_b),
        .req_addr(req_addr), .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b)
    );

    assign req_ready = sel ? rdy_b : rdy_a;
    assign rsp_valid = sel ? rv_b  : rv_a;
    assign rsp_rdata = sel ? rd_b  : rd_a;
    assign rsp_err   = sel ? err_b : err_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Issue one request, expect req_ready low until the response cycle.
    // With scramble set, the request fields are changed during WAIT.
    task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] er, input logic ee,
                         input logic scramble);
        int w;
        int n;
        exp_t e;
        w = sel ? 0 : 2;
        @(negedge clk);
        req_we = we; req_addr = a; req_wstrb = s; req_wdata = d; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
        end else begin
            last_accept = cyc;
            e.rdata = er; e.err = ee; e.cyc = cyc + 1 + w;
            exp_q.push_back(e);
            for (int k = 1; k <= w + 1; k++) begin
                @(negedge clk);
                chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
                if (scramble && k == 1) begin
                    req_addr = a ^ 32'h4; req_wdata = ~d; req_we = ~we; req_wstrb = 4'hF;
                end
            end
            req_valid = 1'b0;
        end
    endtask

    initial begin
        int prev;
        #200000;
        $display("FAIL global_timeout actual=%0d required=done", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int prev;
        #12;
        chk("reset_ready_a", {31'd0, rdy_a}, 32'd0);
        chk("reset_valid_a", {31'd0, rv_a}, 32'd0);
        chk("reset_rdata_a", rd_a, 32'd0);
        chk("reset_err_a", {31'd0, err_a}, 32'd0);
        chk("reset_ready_b", {31'd0, rdy_b}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("ready_before_edge", {31'd0, rdy_a}, 32'd0);
        @(posedge clk);
        #1 chk("ready_after_edge", {31'd0, rdy_a}, 32'd1);

        // Instance A: write then read, byte strobes, errors, hold-off.
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        issue(1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, 1'b0);
        issue(1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 1'b0);
        issue(1'b0, 32'h22, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h22, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 1'b0);
        issue(1'b1, 32'hFFC, 4'hF, 32'h0BADF00D, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'hFFC, 4'h0, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
        issue(1'b1, 32'h34, 4'hF, 32'h01010101, 32'h0, 1'b0, 1'b0);
        issue(1'b1, 32'h30, 4'hF, 32'h55AA55AA, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 32'h34, 4'h0, 32'h0, 32'h01010101, 1'b0, 1'b0);
        issue(1'b0, 32'h30, 4'h0, 32'h0, 32'h55AA55AA, 1'b0, 1'b1);

        // Reset mid-transaction.
        issue(1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h40, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_wstrb = 4'hF; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        chk("abort_ready", {31'd0, rdy_a}, 32'd1);
        @(posedge clk);
        #2 req_valid = 1'b0;
        chk("abort_rdata_held", rd_a, 32'hCAFEF00D);
        #1 reset = 1'b0;
        #1;
        chk("abort_ready_low", {31'd0, rdy_a}, 32'd0);
        chk("abort_valid_low", {31'd0, rv_a}, 32'd0);
        chk("abort_rdata_zero", rd_a, 32'd0);
        chk("abort_err_zero", {31'd0, err_a}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b0, 32'h40, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);

        // Instance B: base 0x1000, 16 words, no wait states.
        @(negedge clk);
        sel = 1'b1;
        issue(1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        issue(1'b1, 32'h103C, 4'hF, 32'h3C3C3C3C, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h1000, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        prev = last_accept;
        issue(1'b0, 32'h103C, 4'h0, 32'h0, 32'h3C3C3C3C, 1'b0, 1'b0);
        chk("b2b_spacing", last_accept - prev, 32'd2);
        issue(1'b0, 32'h0FFC, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h1040, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h1002, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h1000, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
